// File: rtl/shift_arbiter_32_pkg.sv
// Shared types, widths and helpers for the two-requester shift arbiter.
package shift_pkg;

    localparam int SHIFT_W = 32;
    localparam int SHAMT_W = 5;

    // 2'b11 is reserved and executes as a logical right shift.
    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_RSV = 2'b11
    } shift_op_t;

    // The result buffer holds at most one result.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    // Mirror a word so that a right shifter can perform a left shift.
    function automatic logic [SHIFT_W-1:0] bit_reverse(input logic [SHIFT_W-1:0] v);
        logic [SHIFT_W-1:0] r;
        r = '0;
        for (int i = 0; i < SHIFT_W; i++) begin
            r[i] = v[SHIFT_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_arbiter_32_if.sv
// Request/response bundle between requesters, consumer and the shift arbiter.
interface shift_arbiter_32_if;
    import shift_pkg::*;

    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [SHIFT_W-1:0] req_data0;
    logic [SHIFT_W-1:0] req_data1;
    logic [SHAMT_W-1:0] req_amt0;
    logic [SHAMT_W-1:0] req_amt1;
    shift_op_t          req_op0;
    shift_op_t          req_op1;
    logic               resp_valid;
    logic               resp_ready;
    logic               resp_id;
    logic [SHIFT_W-1:0] resp_data;

    // Environment side: drives requests, consumes results.
    modport master (
        output req_valid, req_data0, req_data1, req_amt0, req_amt1, req_op0, req_op1,
        output resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_data0, req_data1, req_amt0, req_amt1, req_op0, req_op1,
        input  resp_ready,
        output req_ready, resp_valid, resp_id, resp_data
    );

endinterface

// File: rtl/shift_arbiter_32_shifter.sv
// Five-stage logarithmic right shifter with a selectable fill bit.
module barrel_shifter_right_32
    import shift_pkg::*;
(
    input  logic [SHIFT_W-1:0] data_i,
    input  logic [SHAMT_W-1:0] amt_i,
    input  logic               fill_i,
    output logic [SHIFT_W-1:0] data_o
);

    logic [SHIFT_W-1:0] stage_s [SHAMT_W+1];

    assign stage_s[0] = data_i;

    // Stage k shifts by 2**k when amt bit k is set.
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int S = 1 << k;
        assign stage_s[k+1] = amt_i[k] ? {{S{fill_i}}, stage_s[k][SHIFT_W-1:S]} : stage_s[k];
    end

    assign data_o = stage_s[SHAMT_W];

endmodule

// File: rtl/shift_arbiter_32.sv
// Two-requester arbiter feeding one shared shifter into a one-entry result buffer.
module shift_arbiter_32
    import shift_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    shift_arbiter_32_if.slave   bus
);

    buf_state_t         state_q, state_d;
    logic               prio_q, prio_d;
    logic               resp_id_q, resp_id_d;
    logic [SHIFT_W-1:0] resp_data_q, resp_data_d;

    logic               grant_s;
    logic               can_accept_s;
    logic               accept_s;
    logic [1:0]         req_ready_s;
    logic [SHIFT_W-1:0] sel_data_s;
    logic [SHAMT_W-1:0] sel_amt_s;
    shift_op_t          sel_op_s;
    logic [SHIFT_W-1:0] shin_s;
    logic [SHIFT_W-1:0] shout_s;
    logic               fill_s;
    logic [SHIFT_W-1:0] result_s;

    // Pick the winner, decide acceptance and drive the one-hot ready.
    always_comb begin
        grant_s = 1'b0;
        if (bus.req_valid == 2'b11) begin
            grant_s = RR_EN ? prio_q : 1'b0;
        end else if (bus.req_valid == 2'b10) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        can_accept_s = (state_q == BUF_EMPTY) | ((state_q == BUF_FULL) & bus.resp_ready);
        // Ready is suppressed while reset is held so nothing is handshaken.
        accept_s     = ~rst & can_accept_s & bus.req_valid[grant_s];
        req_ready_s  = 2'b00;
        if (accept_s) begin
            req_ready_s[grant_s] = 1'b1;
        end else begin
            req_ready_s = 2'b00;
        end
    end

    // Route the winner's operands; SLL runs through the right shifter mirrored.
    always_comb begin
        sel_data_s = grant_s ? bus.req_data1 : bus.req_data0;
        sel_amt_s  = grant_s ? bus.req_amt1  : bus.req_amt0;
        sel_op_s   = grant_s ? bus.req_op1   : bus.req_op0;
        shin_s     = (sel_op_s == OP_SLL) ? bit_reverse(sel_data_s) : sel_data_s;
        fill_s     = (sel_op_s == OP_SRA) & sel_data_s[SHIFT_W-1];
        result_s   = (sel_op_s == OP_SLL) ? bit_reverse(shout_s) : shout_s;
    end

    barrel_shifter_right_32 u_shifter (
        .data_i (shin_s),
        .amt_i  (sel_amt_s),
        .fill_i (fill_s),
        .data_o (shout_s)
    );

    // Buffer FSM next state, captured result and round-robin pointer.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        resp_id_d   = resp_id_q;
        resp_data_d = resp_data_q;
        if (accept_s) begin
            prio_d      = ~grant_s;
            resp_id_d   = grant_s;
            resp_data_d = result_s;
        end else begin
            prio_d      = prio_q;
        end
        case (state_q)
            BUF_EMPTY: state_d = accept_s ? BUF_FULL : BUF_EMPTY;
            BUF_FULL:  state_d = (bus.resp_ready & ~accept_s) ? BUF_EMPTY : BUF_FULL;
            default:   state_d = BUF_EMPTY;
        endcase
    end

    // State and result registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BUF_EMPTY;
            prio_q      <= 1'b0;
            resp_id_q   <= 1'b0;
            resp_data_q <= {SHIFT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            resp_id_q   <= resp_id_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign bus.req_ready  = req_ready_s;
    assign bus.resp_valid = (state_q == BUF_FULL);
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_shift_arbiter_32.sv
// Directed bench for shift_arbiter_32: a vector table plus multi-cycle sequences.
module tb_shift_arbiter_32;
    import shift_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [31:0] d0, d1;
    logic [4:0]  a0, a1;
    logic [1:0]  o0, o1;
    logic        resp_ready;

    int n_vec;
    int n_err;

    shift_arbiter_32_if rr_if ();
    shift_arbiter_32_if fp_if ();

    assign rr_if.req_valid  = req_valid;
    assign rr_if.req_data0  = d0;
    assign rr_if.req_data1  = d1;
    assign rr_if.req_amt0   = a0;
    assign rr_if.req_amt1   = a1;
    assign rr_if.req_op0    = shift_op_t'(o0);
    assign rr_if.req_op1    = shift_op_t'(o1);
    assign rr_if.resp_ready = resp_ready;
    assign fp_if.req_valid  = req_valid;
    assign fp_if.req_data0  = d0;
    assign fp_if.req_data1  = d1;
    assign fp_if.req_amt0   = a0;
    assign fp_if.req_amt1   = a1;
    assign fp_if.req_op0    = shift_op_t'(o0);
    assign fp_if.req_op1    = shift_op_t'(o1);
    assign fp_if.resp_ready = resp_ready;

    shift_arbiter_32 #(.RR_EN(1'b1)) u_rr (.clk(clk), .rst(rst), .bus(rr_if.slave));
    shift_arbiter_32 #(.RR_EN(1'b0)) u_fp (.clk(clk), .rst(rst), .bus(fp_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] d0;
        logic [4:0]  a0;
        logic [1:0]  o0;
        logic [31:0] d1;
        logic [4:0]  a1;
        logic [1:0]  o1;
        logic [31:0] exp_data;
        logic        exp_id;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_d;
        logic        exp_id;
        logic [1:0]  rr_ids [5];

        n_vec = 0;
        n_err = 0;
        rst        = 1'b1;
        req_valid  = 2'b11;
        d0 = 32'h0; d1 = 32'h0; a0 = 5'd0; a1 = 5'd0; o0 = 2'b00; o1 = 2'b00;
        resp_ready = 1'b1;

        tbl[0]  = '{2'b01, 32'h8000_0000, 5'd4,  2'b10, 32'h0,         5'd0,  2'b00, 32'hF800_0000, 1'b0};
        tbl[1]  = '{2'b10, 32'h0,         5'd0,  2'b00, 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 1'b1};
        tbl[2]  = '{2'b10, 32'h0,         5'd0,  2'b00, 32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 1'b1};
        tbl[3]  = '{2'b01, 32'hDEAD_BEEF, 5'd0,  2'b00, 32'h0,         5'd0,  2'b00, 32'hDEAD_BEEF, 1'b0};
        tbl[4]  = '{2'b01, 32'hDEAD_BEEF, 5'd0,  2'b01, 32'h0,         5'd0,  2'b00, 32'hDEAD_BEEF, 1'b0};
        tbl[5]  = '{2'b01, 32'hDEAD_BEEF, 5'd0,  2'b10, 32'h0,         5'd0,  2'b00, 32'hDEAD_BEEF, 1'b0};
        tbl[6]  = '{2'b10, 32'h0,         5'd0,  2'b00, 32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF, 1'b1};
        tbl[7]  = '{2'b01, 32'hF000_0000, 5'd4,  2'b11, 32'h0,         5'd0,  2'b00, 32'h0F00_0000, 1'b0};
        tbl[8]  = '{2'b10, 32'h0,         5'd0,  2'b00, 32'hF000_0000, 5'd4,  2'b10, 32'hFF00_0000, 1'b1};
        tbl[9]  = '{2'b01, 32'h0000_00F1, 5'd4,  2'b00, 32'h0,         5'd0,  2'b00, 32'h0000_0F10, 1'b0};
        tbl[10] = '{2'b10, 32'h0,         5'd0,  2'b00, 32'h1234_5678, 5'd8,  2'b00, 32'h3456_7800, 1'b1};
        tbl[11] = '{2'b01, 32'h7000_0000, 5'd31, 2'b10, 32'h0,         5'd0,  2'b00, 32'h0000_0000, 1'b0};
        tbl[12] = '{2'b10, 32'h0,         5'd0,  2'b00, 32'h8765_4321, 5'd16, 2'b10, 32'hFFFF_8765, 1'b1};
        tbl[13] = '{2'b01, 32'h8765_4321, 5'd1,  2'b01, 32'h0,         5'd0,  2'b00, 32'h43B2_A190, 1'b0};

        // Reset state, with both requests pending.
        #3;
        check("rst_req_ready", {30'd0, rr_if.req_ready}, 32'h0);
        check("rst_resp_valid", {31'd0, rr_if.resp_valid}, 32'h0);
        check("rst_resp_data", rr_if.resp_data, 32'h0);
        check("rst_resp_id", {31'd0, rr_if.resp_id}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 2'b00;

        // Table: one result per cycle with resp_ready held high.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            req_valid = tbl[i].valid;
            d0 = tbl[i].d0; a0 = tbl[i].a0; o0 = tbl[i].o0;
            d1 = tbl[i].d1; a1 = tbl[i].a1; o1 = tbl[i].o1;
            #2;
            check($sformatf("v%0d_req_ready", i), {30'd0, rr_if.req_ready}, {30'd0, tbl[i].valid});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_resp_valid", i), {31'd0, rr_if.resp_valid}, 32'h1);
            check($sformatf("v%0d_resp_data", i), rr_if.resp_data, tbl[i].exp_data);
            check($sformatf("v%0d_resp_id", i), {31'd0, rr_if.resp_id}, {31'd0, tbl[i].exp_id});
        end

        // Reset pulse in the middle of a cycle while the buffer is full.
        @(negedge clk);
        req_valid = 2'b11;
        d0 = 32'h0000_0001; a0 = 5'd1; o0 = 2'b00;
        d1 = 32'h0000_0001; a1 = 5'd2; o1 = 2'b00;
        rst = 1'b1;
        #1;
        check("midrst_resp_valid", {31'd0, rr_if.resp_valid}, 32'h0);
        check("midrst_req_ready", {30'd0, rr_if.req_ready}, 32'h0);
        check("midrst_resp_data", rr_if.resp_data, 32'h0);
        #1;
        rst = 1'b0;

        // Both valid: round-robin alternates from 0, fixed priority keeps 0.
        rr_ids[0] = 2'd0; rr_ids[1] = 2'd1; rr_ids[2] = 2'd0; rr_ids[3] = 2'd1; rr_ids[4] = 2'd0;
        for (int c = 0; c < 5; c++) begin
            if (c != 0) @(negedge clk);
            #2;
            check($sformatf("rr%0d_req_ready", c), {30'd0, rr_if.req_ready},
                  (rr_ids[c] == 2'd0) ? 32'h1 : 32'h2);
            check($sformatf("fp%0d_req_ready", c), {30'd0, fp_if.req_ready}, 32'h1);
            @(posedge clk);
            #1;
            check($sformatf("rr%0d_resp_valid", c), {31'd0, rr_if.resp_valid}, 32'h1);
            check($sformatf("rr%0d_resp_id", c), {31'd0, rr_if.resp_id}, {30'd0, rr_ids[c]});
            check($sformatf("rr%0d_resp_data", c), rr_if.resp_data,
                  (rr_ids[c] == 2'd0) ? 32'h0000_0002 : 32'h0000_0004);
            check($sformatf("fp%0d_resp_id", c), {31'd0, fp_if.resp_id}, 32'h0);
            check($sformatf("fp%0d_resp_data", c), fp_if.resp_data, 32'h0000_0002);
        end

        // Consumer stalls for three cycles: buffer holds, no requester accepted.
        exp_d  = 32'h0000_0002;
        exp_id = 1'b0;
        @(negedge clk);
        resp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            check($sformatf("stall%0d_req_ready", c), {30'd0, rr_if.req_ready}, 32'h0);
            @(posedge clk);
            #1;
            check($sformatf("stall%0d_resp_valid", c), {31'd0, rr_if.resp_valid}, 32'h1);
            check($sformatf("stall%0d_resp_data", c), rr_if.resp_data, exp_d);
            check($sformatf("stall%0d_resp_id", c), {31'd0, rr_if.resp_id}, {31'd0, exp_id});
            @(negedge clk);
        end

        // Release with req0 valid: accepted in the same cycle, then back-to-back.
        resp_ready = 1'b1;
        req_valid  = 2'b01;
        d0 = 32'h0000_00F0; a0 = 5'd4; o0 = 2'b01;
        #2;
        check("pass_req_ready", {30'd0, rr_if.req_ready}, 32'h1);
        @(posedge clk);
        #1;
        check("pass_resp_data", rr_if.resp_data, 32'h0000_000F);
        check("pass_resp_id", {31'd0, rr_if.resp_id}, 32'h0);
        @(negedge clk);
        d0 = 32'hA000_0000; a0 = 5'd1; o0 = 2'b10;
        #2;
        check("b2b_req_ready", {30'd0, rr_if.req_ready}, 32'h1);
        @(posedge clk);
        #1;
        check("b2b_resp_valid", {31'd0, rr_if.resp_valid}, 32'h1);
        check("b2b_resp_data", rr_if.resp_data, 32'hD000_0000);

        // Drain: buffer empties but keeps its last data.
        @(negedge clk);
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        check("drain_resp_valid", {31'd0, rr_if.resp_valid}, 32'h0);
        check("drain_resp_data", rr_if.resp_data, 32'hD000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
